// File: rtl/i2c_master_bit_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_master_bit_ctrl
//
// Bit-level engine of the I2C master. Executes one bit command at a time
// (START, STOP, WRITE, READ) by stepping the open-drain SCL/SDA enables
// through timed phases. Each phase lasts Clk_cnt+1 Clk cycles.
//
// Optional feature macro: I2C_CLK_STRETCH_EN
//   defined   : the prescaler stalls while SCL is released but still low
//               (slave clock stretching).
//   undefined : phases are always exactly Clk_cnt+1 cycles.
//
// Ports
//   Clk, Rst_n         clock, asynchronous active-low reset
//   Ena                core enable (gates acceptance of new commands)
//   Clk_cnt            phase length minus one
//   Bit_cmd, Bit_txd   command (NOP/START/STOP/WRITE/READ) and write bit
//   Bit_ack            one-cycle pulse, command completed
//   Bit_rxd            SDA sampled at the SCL high phase of READ/WRITE
//   I2C_al             one-cycle pulse, arbitration lost
//   Busy               bus busy between a START and a STOP seen on the bus
//   Scl_i, Sda_i       asynchronous pad inputs
//   Scl_o, Sda_o       constant 0 (open drain)
//   Scl_oen, Sda_oen   active-low output enables, 1 releases the line
// ---------------------------------------------------------------------------
module i2c_master_bit_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Ena,
   input  logic [CNT_W-1:0] Clk_cnt,
   input  logic [3:0]       Bit_cmd,
   input  logic             Bit_txd,
   output logic             Bit_ack,
   output logic             Bit_rxd,
   output logic             I2C_al,
   output logic             Busy,
   input  logic             Scl_i,
   input  logic             Sda_i,
   output logic             Scl_o,
   output logic             Sda_o,
   output logic             Scl_oen,
   output logic             Sda_oen
);

   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_START_A, ST_START_B, ST_START_C, ST_START_D, ST_START_E,
      ST_STOP_A,  ST_STOP_B,  ST_STOP_C,  ST_STOP_D,
      ST_WR_A,    ST_WR_B,    ST_WR_C,    ST_WR_D,
      ST_RD_A,    ST_RD_B,    ST_RD_C,    ST_RD_D
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       cmd_reg;
   logic             txd_reg;
   // [0],[1] synchronizer, [2] previous synchronized value
   logic [2:0]       scl_sync_reg;
   logic [2:0]       sda_sync_reg;
   // Sda_oen delayed by the synchronizer depth, so the arbitration check
   // only compares SDA against a release the synchronizer has had time to see.
   logic [1:0]       sda_oen_dly_reg;

   logic scl_s, sda_s, scl_prev, sda_prev;
   logic start_cond, stop_cond, sda_chk, al_now, stall;

   assign Scl_o = 1'b0;
   assign Sda_o = 1'b0;

   assign scl_s    = scl_sync_reg[1];
   assign sda_s    = sda_sync_reg[1];
   assign scl_prev = scl_sync_reg[2];
   assign sda_prev = sda_sync_reg[2];

   // Bus conditions require SCL high on both samples so SDA moved while SCL stayed high
   assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;

   assign sda_chk = ((state_reg == ST_WR_C) & txd_reg) |
                    (state_reg == ST_STOP_C) | (state_reg == ST_STOP_D);

   assign al_now = (sda_chk & Sda_oen & sda_oen_dly_reg[1] & scl_s & ~sda_s) |
                   ((state_reg != ST_IDLE) & stop_cond & (cmd_reg != CMD_STOP));

`ifdef I2C_CLK_STRETCH_EN
   assign stall = Scl_oen & ~scl_s;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         cmd_reg         <= 4'b0000;
         txd_reg         <= 1'b0;
         scl_sync_reg    <= 3'b111;
         sda_sync_reg    <= 3'b111;
         sda_oen_dly_reg <= 2'b11;
         Scl_oen         <= 1'b1;
         Sda_oen         <= 1'b1;
         Bit_ack         <= 1'b0;
         Bit_rxd         <= 1'b0;
         I2C_al          <= 1'b0;
         Busy            <= 1'b0;
      end else begin
         scl_sync_reg    <= {scl_sync_reg[1:0], Scl_i};
         sda_sync_reg    <= {sda_sync_reg[1:0], Sda_i};
         sda_oen_dly_reg <= {sda_oen_dly_reg[0], Sda_oen};
         Bit_ack         <= 1'b0;
         I2C_al          <= 1'b0;

         if (start_cond)
            Busy <= 1'b1;
         else if (stop_cond)
            Busy <= 1'b0;

         if (al_now) begin
            state_reg <= ST_IDLE;
            Scl_oen   <= 1'b1;
            Sda_oen   <= 1'b1;
            I2C_al    <= 1'b1;
         end else if (state_reg == ST_IDLE) begin
            // Bit_ack high means the upstream command is still the one just done
            if (Ena && !Bit_ack) begin
               cmd_reg <= Bit_cmd;
               txd_reg <= Bit_txd;
               cnt_reg <= Clk_cnt;
               case (Bit_cmd)
                  CMD_START: begin state_reg <= ST_START_A; Sda_oen <= 1'b1; end
                  CMD_STOP:  begin state_reg <= ST_STOP_A;  Scl_oen <= 1'b0; Sda_oen <= 1'b0; end
                  CMD_WRITE: begin state_reg <= ST_WR_A;    Scl_oen <= 1'b0; Sda_oen <= Bit_txd; end
                  CMD_READ:  begin state_reg <= ST_RD_A;    Scl_oen <= 1'b0; Sda_oen <= 1'b1; end
                  default:   state_reg <= ST_IDLE;
               endcase
            end
         end else if (stall) begin
            cnt_reg <= cnt_reg;
         end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end else begin
            cnt_reg <= Clk_cnt;
            case (state_reg)
               ST_START_A: begin state_reg <= ST_START_B; Scl_oen <= 1'b1; Sda_oen <= 1'b1; end
               ST_START_B: begin state_reg <= ST_START_C; Scl_oen <= 1'b1; Sda_oen <= 1'b0; end
               ST_START_C: begin state_reg <= ST_START_D; Scl_oen <= 1'b1; Sda_oen <= 1'b0; end
               ST_START_D: begin state_reg <= ST_START_E; Scl_oen <= 1'b0; Sda_oen <= 1'b0; end
               ST_STOP_A:  begin state_reg <= ST_STOP_B;  Scl_oen <= 1'b1; Sda_oen <= 1'b0; end
               ST_STOP_B:  begin state_reg <= ST_STOP_C;  Scl_oen <= 1'b1; Sda_oen <= 1'b0; end
               ST_STOP_C:  begin state_reg <= ST_STOP_D;  Scl_oen <= 1'b1; Sda_oen <= 1'b1; end
               ST_WR_A:    begin state_reg <= ST_WR_B;    Scl_oen <= 1'b1; end
               ST_WR_B:    begin state_reg <= ST_WR_C;    Bit_rxd <= sda_s; end
               ST_WR_C:    begin state_reg <= ST_WR_D;    Scl_oen <= 1'b0; end
               ST_RD_A:    begin state_reg <= ST_RD_B;    Scl_oen <= 1'b1; end
               ST_RD_B:    begin state_reg <= ST_RD_C;    Bit_rxd <= sda_s; end
               ST_RD_C:    begin state_reg <= ST_RD_D;    Scl_oen <= 1'b0; end
               ST_START_E, ST_STOP_D, ST_WR_D, ST_RD_D: begin
                  state_reg <= ST_IDLE;
                  Bit_ack   <= 1'b1;
               end
               default:    state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_bit_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_master_bit_ctrl
//
// Directed bench for i2c_master_bit_ctrl with an open-drain bus model:
// each line is the AND of the master drive and an external pull-down
// (slave / other master). Expected latencies are hand-derived from the
// phase counts; stretching builds add the synchronizer stall on phases
// that release SCL from low.
// ---------------------------------------------------------------------------
module tb_i2c_master_bit_ctrl;

   localparam int CNT_W = 16;
`ifdef I2C_CLK_STRETCH_EN
   localparam int STR      = 2;
   localparam int HOLD_DLY = 40;
`else
   localparam int STR      = 0;
   localparam int HOLD_DLY = 0;
`endif

   localparam logic [3:0] NOP   = 4'b0000;
   localparam logic [3:0] START = 4'b0001;
   localparam logic [3:0] STOP  = 4'b0010;
   localparam logic [3:0] WRITE = 4'b0100;
   localparam logic [3:0] READ  = 4'b1000;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic             Ena = 1'b0;
   logic [CNT_W-1:0] Clk_cnt = 16'd3;
   logic [3:0]       Bit_cmd = 4'b0000;
   logic             Bit_txd = 1'b0;
   logic             Bit_ack, Bit_rxd, I2C_al, Busy;
   logic             Scl_o, Sda_o, Scl_oen, Sda_oen;
   logic             scl_hold = 1'b0;
   logic             sda_low  = 1'b0;
   logic             scl_bus, sda_bus;

   assign scl_bus = (Scl_oen ? 1'b1 : Scl_o) & ~scl_hold;
   assign sda_bus = (Sda_oen ? 1'b1 : Sda_o) & ~sda_low;

   i2c_master_bit_ctrl #(.CNT_W(CNT_W)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Ena     (Ena),
      .Clk_cnt (Clk_cnt),
      .Bit_cmd (Bit_cmd),
      .Bit_txd (Bit_txd),
      .Bit_ack (Bit_ack),
      .Bit_rxd (Bit_rxd),
      .I2C_al  (I2C_al),
      .Busy    (Busy),
      .Scl_i   (scl_bus),
      .Sda_i   (sda_bus),
      .Scl_o   (Scl_o),
      .Sda_o   (Sda_o),
      .Scl_oen (Scl_oen),
      .Sda_oen (Sda_oen)
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Per-command observations filled in by run_cmd
   int   lat, start_n, busy_n, wcnt;
   logic got_ack, got_al, start_seen, stop_seen, min_oen;

   task automatic run_cmd(input logic [3:0] cmd, input logic txd, input string name);
      logic p_scl, p_sda, p_busy;
      @(negedge Clk);
      Bit_cmd = cmd;
      Bit_txd = txd;
      Ena     = 1'b1;
      lat = 0; start_n = -1; busy_n = -1;
      got_ack = 1'b0; got_al = 1'b0; start_seen = 1'b0; stop_seen = 1'b0; min_oen = 1'b1;
      p_scl = scl_bus; p_sda = sda_bus; p_busy = Busy;
      while (!got_ack && !got_al && lat < 400) begin
         @(negedge Clk);
         lat++;
         if (!Sda_oen) min_oen = 1'b0;
         if (p_scl && scl_bus && p_sda && !sda_bus) begin start_seen = 1'b1; start_n = lat; end
         if (p_scl && scl_bus && !p_sda && sda_bus) stop_seen = 1'b1;
         if (Busy && !p_busy) busy_n = lat;
         if (Bit_ack) got_ack = 1'b1;
         if (I2C_al)  got_al  = 1'b1;
         p_scl = scl_bus; p_sda = sda_bus; p_busy = Busy;
      end
      Bit_cmd = NOP;
      check_val({name, "_done"}, 32'(got_ack | got_al), 1);
      $display("%0t %s txd=%0d clk_cnt=%0d lat=%0d ack=%0d al=%0d rxd=%0d busy=%0d",
               $time, name, txd, Clk_cnt, lat, got_ack, got_al, Bit_rxd, Busy);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge Clk);
      check_val("rst_scl_oen", 32'(Scl_oen), 1);
      check_val("rst_sda_oen", 32'(Sda_oen), 1);
      check_val("rst_ack",     32'(Bit_ack), 0);
      check_val("rst_rxd",     32'(Bit_rxd), 0);
      check_val("rst_al",      32'(I2C_al),  0);
      check_val("rst_busy",    32'(Busy),    0);
      Rst_n = 1'b1;

      // Ena low: command must not be accepted
      @(negedge Clk);
      Bit_cmd = START;
      repeat (25) @(negedge Clk);
      check_val("ena0_sda_oen", 32'(Sda_oen), 1);
      check_val("ena0_busy",    32'(Busy),    0);
      Bit_cmd = NOP;

      // START on an idle bus
      run_cmd(START, 1'b0, "START");
      check_val("start_lat",    32'(lat), 21);
      check_val("start_seen",   32'(start_seen), 1);
      check_val("start_busy_dly", 32'(busy_n - start_n), 3);
      check_val("start_busy",   32'(Busy), 1);
      check_val("start_scl_oen", 32'(Scl_oen), 0);

      // WRITE 0 then WRITE 1, passive slave
      run_cmd(WRITE, 1'b0, "WRITE0");
      check_val("wr0_lat",  32'(lat), 17 + STR);
      check_val("wr0_drv",  32'(min_oen), 0);
      check_val("wr0_rxd",  32'(Bit_rxd), 0);
      check_val("wr0_al",   32'(got_al), 0);
      run_cmd(WRITE, 1'b1, "WRITE1");
      check_val("wr1_lat",  32'(lat), 17 + STR);
      check_val("wr1_drv",  32'(min_oen), 1);
      check_val("wr1_rxd",  32'(Bit_rxd), 1);
      check_val("wr1_al",   32'(got_al), 0);

      // READ with the slave holding SDA low
      sda_low = 1'b1;
      run_cmd(READ, 1'b0, "READ_SLV0");
      check_val("rd_lat",   32'(lat), 17 + STR);
      check_val("rd_oen",   32'(min_oen), 1);
      check_val("rd_rxd",   32'(Bit_rxd), 0);
      check_val("rd_al",    32'(got_al), 0);
      sda_low = 1'b0;

      // WRITE 1 against another master holding SDA low -> arbitration lost
      @(negedge Clk);
      sda_low = 1'b1;
      run_cmd(WRITE, 1'b1, "WRITE_ARB");
      check_val("arb_al",      32'(got_al), 1);
      check_val("arb_ack",     32'(got_ack), 0);
      check_val("arb_scl_oen", 32'(Scl_oen), 1);
      check_val("arb_sda_oen", 32'(Sda_oen), 1);
      sda_low = 1'b0;  // other master releases: STOP seen on the bus
      repeat (5) @(negedge Clk);
      check_val("arb_busy_clr", 32'(Busy), 0);

      // Next command accepted normally
      run_cmd(START, 1'b0, "START2");
      check_val("start2_lat", 32'(lat), 21);
      check_val("start2_ack", 32'(got_ack), 1);

      // Short phases
      Clk_cnt = 16'd1;
      run_cmd(READ, 1'b0, "READ_CC1");
      check_val("rd_cc1_lat", 32'(lat), 9 + STR);
      check_val("rd_cc1_rxd", 32'(Bit_rxd), 1);
      Clk_cnt = 16'd0;
      run_cmd(WRITE, 1'b1, "WRITE_CC0");
      check_val("wr_cc0_lat", 32'(lat), 5 + STR);
      check_val("wr_cc0_al",  32'(got_al), 0);
      Clk_cnt = 16'd3;

      // Slave stretches SCL for 40 cycles from the start of WR_B
      scl_hold = 1'b1;
      fork
         run_cmd(WRITE, 1'b0, "WRITE_STRETCH");
         begin
            wcnt = 0;
            while (!Scl_oen && wcnt < 200) begin
               @(negedge Clk);
               wcnt++;
            end
            repeat (40) @(negedge Clk);
            scl_hold = 1'b0;
         end
      join
      check_val("stretch_lat", 32'(lat), 17 + STR + HOLD_DLY);

      // STOP after WRITE
      run_cmd(STOP, 1'b0, "STOP");
      check_val("stop_lat",  32'(lat), 17 + STR);
      check_val("stop_seen", 32'(stop_seen), 1);
      check_val("stop_busy", 32'(Busy), 0);
      check_val("stop_al",   32'(got_al), 0);

      // Reset in the middle of a STOP
      run_cmd(START, 1'b0, "START3");
      @(negedge Clk);
      Bit_cmd = STOP;
      @(negedge Clk);
      Bit_cmd = NOP;
      @(negedge Clk);
      check_val("mid_stop_scl_drv", 32'(Scl_oen), 0);
      check_val("mid_stop_sda_drv", 32'(Sda_oen), 0);
      Rst_n = 1'b0;
      #1;
      check_val("rst_mid_scl_oen", 32'(Scl_oen), 1);
      check_val("rst_mid_sda_oen", 32'(Sda_oen), 1);
      check_val("rst_mid_busy",    32'(Busy), 0);
      check_val("rst_mid_ack",     32'(Bit_ack), 0);
      $display("%0t RESET_MID_STOP scl_oen=%0d sda_oen=%0d", $time, Scl_oen, Sda_oen);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
